// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state_e;

  localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_STEP           = 32'd4;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
    logic        valid;
  } ifid_t;

  // A bubble keeps the previous PC+4 so Decode still sees a sensible link value.
  function automatic ifid_t make_bubble(input logic [31:0] nop, input logic [31:0] pc_plus4);
    ifid_t b;
    b.instr    = nop;
    b.pc_plus4 = pc_plus4;
    b.valid    = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry buffer that parks a fetched word while Decode is stalled.
module fetch_hold_buf
  import fetch_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  load,
  input  logic  drain,
  input  logic  clear,
  input  ifid_t load_data,
  output logic  hold_valid,
  output ifid_t hold_data
);

  logic  valid_reg;
  ifid_t data_reg;

  // Clear wins over load: a redirect squashes whatever was arriving.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
    end else if (clear) begin
      valid_reg <= 1'b0;
    end else if (load) begin
      valid_reg <= 1'b1;
      data_reg  <= load_data;
    end else if (drain) begin
      valid_reg <= 1'b0;
    end
  end

  assign hold_valid = valid_reg;
  assign hold_data  = data_reg;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC, imem request FSM, hold buffer and IF/ID register.
// Optional macro DELAY_SLOT_EN selects MIPS branch-delay-slot semantics instead of squashing.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_F_n,
  input  logic        stall_D_n,
  input  logic        pc_src_D,
  input  logic [31:0] pc_branch_D,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_D,
  output logic [31:0] pc_plus4_D,
  output logic        valid_D,
  output logic        fetch_busy
);

  fetch_state_e state_reg, state_next;
  logic [31:0]  pc_reg, pc_next;
  logic [31:0]  wait_addr_reg;
  logic         kill_reg, kill_next;
  ifid_t        ifid_reg, ifid_next;

  logic         hold_valid;
  ifid_t        hold_data;
  logic         hold_load, hold_drain, hold_clear;

  logic         accept;
  logic         outstanding;
  logic         redirect;
  logic [31:0]  addr_plus4;
  ifid_t        fetched;
  ifid_t        bubble;

  fetch_hold_buf u_hold (
    .clk        (clk),
    .rst        (rst),
    .load       (hold_load),
    .drain      (hold_drain),
    .clear      (hold_clear),
    .load_data  (fetched),
    .hold_valid (hold_valid),
    .hold_data  (hold_data)
  );

  // Request side: in WAIT the address comes from a frozen copy, since pc_reg
  // may already have moved to a redirect target.
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = pc_reg;
    case (state_reg)
      REQ: begin
        imem_req = stall_F_n & ~hold_valid;
      end
      WAIT: begin
        imem_req  = 1'b1;
        imem_addr = wait_addr_reg;
      end
      default: begin
        imem_req = 1'b0;
      end
    endcase
  end

  assign accept      = imem_req & imem_ready;
  assign outstanding = imem_req & ~imem_ready;
  assign redirect    = pc_src_D & stall_D_n;
  assign fetch_busy  = outstanding;
  assign addr_plus4  = imem_addr + PC_STEP;
  assign fetched     = '{instr: imem_rdata, pc_plus4: addr_plus4, valid: 1'b1};
  assign bubble      = make_bubble(NOP_INSTR, ifid_reg.pc_plus4);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    state_next = REQ;
      REQ:     state_next = outstanding ? WAIT : REQ;
      WAIT:    state_next = imem_ready ? REQ : WAIT;
      default: state_next = IDLE;
    endcase
  end

`ifdef DELAY_SLOT_EN
  logic        redir_valid_reg, redir_valid_next;
  logic [31:0] redir_target_reg, redir_target_next;

  always_comb begin
    pc_next           = pc_reg;
    kill_next         = kill_reg;
    ifid_next         = ifid_reg;
    hold_load         = 1'b0;
    hold_drain        = 1'b0;
    hold_clear        = 1'b0;
    redir_valid_next  = redir_valid_reg;
    redir_target_next = redir_target_reg;
    if (redirect) begin
      hold_clear = 1'b1;
      if (accept) begin
        pc_next          = pc_branch_D;
        ifid_next        = fetched;
        redir_valid_next = 1'b0;
      end else if (hold_valid) begin
        pc_next          = pc_branch_D;
        ifid_next        = hold_data;
        redir_valid_next = 1'b0;
      end else begin
        // Slot word not yet accepted: remember the target until it arrives.
        ifid_next         = bubble;
        redir_valid_next  = 1'b1;
        redir_target_next = pc_branch_D;
      end
    end else if (accept) begin
      pc_next          = redir_valid_reg ? redir_target_reg : addr_plus4;
      redir_valid_next = 1'b0;
      if (stall_D_n) ifid_next = fetched;
      else           hold_load = 1'b1;
    end else if (stall_D_n) begin
      if (hold_valid) begin
        ifid_next  = hold_data;
        hold_drain = 1'b1;
      end else begin
        ifid_next = bubble;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redir_valid_reg  <= 1'b0;
      redir_target_reg <= RESET_PC;
    end else begin
      redir_valid_reg  <= redir_valid_next;
      redir_target_reg <= redir_target_next;
    end
  end
`else
  always_comb begin
    pc_next    = pc_reg;
    kill_next  = kill_reg;
    ifid_next  = ifid_reg;
    hold_load  = 1'b0;
    hold_drain = 1'b0;
    hold_clear = 1'b0;
    if (redirect) begin
      // Any request that cannot be withdrawn this cycle must have its data dropped later.
      pc_next    = pc_branch_D;
      ifid_next  = bubble;
      hold_clear = 1'b1;
      kill_next  = outstanding;
    end else if (accept && kill_reg) begin
      kill_next = 1'b0;
      if (stall_D_n) ifid_next = bubble;
    end else if (accept) begin
      pc_next = addr_plus4;
      if (stall_D_n) ifid_next = fetched;
      else           hold_load = 1'b1;
    end else if (stall_D_n) begin
      if (hold_valid) begin
        ifid_next  = hold_data;
        hold_drain = 1'b1;
      end else begin
        ifid_next = bubble;
      end
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      pc_reg        <= RESET_PC;
      wait_addr_reg <= RESET_PC;
      kill_reg      <= 1'b0;
      ifid_reg      <= '{instr: NOP_INSTR, pc_plus4: 32'h0, valid: 1'b0};
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      kill_reg  <= kill_next;
      ifid_reg  <= ifid_next;
      if (state_reg == REQ) wait_addr_reg <= pc_reg;
    end
  end

  assign instr_D    = ifid_reg.instr;
  assign pc_plus4_D = ifid_reg.pc_plus4;
  assign valid_D    = ifid_reg.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, async-reset sequence, randomized run vs a transaction model.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_F_n, stall_D_n, pc_src_D, imem_ready;
  logic [31:0] pc_branch_D;
  logic        imem_req, valid_D, fetch_busy;
  logic [31:0] imem_addr, imem_rdata, instr_D, pc_plus4_D;

  int n_cmp = 0;
  int n_bad = 0;
  int n_step = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  fetch_stage #(.RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall_F_n   (stall_F_n),
    .stall_D_n   (stall_D_n),
    .pc_src_D    (pc_src_D),
    .pc_branch_D (pc_branch_D),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .instr_D     (instr_D),
    .pc_plus4_D  (pc_plus4_D),
    .valid_D     (valid_D),
    .fetch_busy  (fetch_busy)
  );

  typedef struct {
    bit          sf, sd, ps;
    logic [31:0] pb;
    bit          rdy;
    bit          e_req;
    logic [31:0] e_addr;
    bit          e_busy, e_valid;
    logic [31:0] e_pc4;
  } vec_t;

  function automatic vec_t mk(bit sf, bit sd, bit ps, logic [31:0] pb, bit rdy,
                              bit er, logic [31:0] ea, bit eb, bit ev, logic [31:0] ep);
    vec_t v;
    v.sf = sf; v.sd = sd; v.ps = ps; v.pb = pb; v.rdy = rdy;
    v.e_req = er; v.e_addr = ea; v.e_busy = eb; v.e_valid = ev; v.e_pc4 = ep;
    return v;
  endfunction

  // Transaction-level model: an outstanding request record, a hold queue and the IF/ID contents.
  bit          m_started;
  logic [31:0] m_pc;
  bit          m_out_valid, m_out_kill;
  logic [31:0] m_out_addr;
  logic [63:0] m_hold[$];
  logic [31:0] m_instr, m_pc4;
  bit          m_valid;
  bit          e_req;
  logic [31:0] e_addr;

  task automatic model_reset();
    m_started = 0; m_pc = 32'h0; m_out_valid = 0; m_out_kill = 0; m_out_addr = 32'h0;
    m_hold.delete();
    m_instr = NOP; m_pc4 = 32'h0; m_valid = 0;
  endtask

  task automatic model_outputs();
    if (!m_started) begin
      e_req = 0; e_addr = m_pc;
    end else if (m_out_valid) begin
      e_req = 1; e_addr = m_out_addr;
    end else begin
      e_req = stall_F_n && (m_hold.size() == 0); e_addr = m_pc;
    end
  endtask

  task automatic model_update();
    bit acc, pend, killed, redir;
    logic [31:0] word;
    logic [63:0] h;
    acc    = e_req && imem_ready;
    pend   = e_req && !imem_ready;
    killed = acc && m_out_valid && m_out_kill;
    redir  = pc_src_D && stall_D_n;
    word   = mem_word(e_addr);
    if (redir) begin
      m_pc = pc_branch_D; m_instr = NOP; m_valid = 0; m_hold.delete();
      m_out_valid = pend; m_out_kill = pend; m_out_addr = e_addr;
    end else begin
      if (pend) begin
        m_out_kill = m_out_valid && m_out_kill;
        m_out_valid = 1; m_out_addr = e_addr;
      end else begin
        m_out_valid = 0; m_out_kill = 0;
      end
      if (acc && !killed) begin
        m_pc = e_addr + 32'd4;
        if (stall_D_n) begin
          m_instr = word; m_pc4 = e_addr + 32'd4; m_valid = 1;
        end else begin
          m_hold.push_back({word, e_addr + 32'd4});
        end
      end else if (stall_D_n) begin
        if (m_hold.size() > 0) begin
          h = m_hold.pop_front();
          m_instr = h[63:32]; m_pc4 = h[31:0]; m_valid = 1;
        end else begin
          m_instr = NOP; m_valid = 0;
        end
      end
    end
    m_started = 1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @step %0d: got %h, expected %h", name, n_step, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req"}, {31'b0, imem_req}, 32'd0);
    chk({tag, "_busy"}, {31'b0, fetch_busy}, 32'd0);
    chk({tag, "_valid_D"}, {31'b0, valid_D}, 32'd0);
    chk({tag, "_instr_D"}, instr_D, NOP);
    chk({tag, "_pc4_D"}, pc_plus4_D, 32'd0);
  endtask

  task automatic step(input vec_t v, input bit use_exp);
    logic [31:0] a;
    stall_F_n = v.sf; stall_D_n = v.sd; pc_src_D = v.ps; pc_branch_D = v.pb; imem_ready = v.rdy;
    @(negedge clk);
    model_outputs();
    chk("req", {31'b0, imem_req}, {31'b0, e_req});
    if (e_req) chk("addr", imem_addr, e_addr);
    chk("busy", {31'b0, fetch_busy}, {31'b0, e_req & ~v.rdy});
    chk("instr_D", instr_D, m_instr);
    chk("pc4_D", pc_plus4_D, m_pc4);
    chk("valid_D", {31'b0, valid_D}, {31'b0, m_valid});
    if (use_exp) begin
      chk("tbl_req", {31'b0, imem_req}, {31'b0, v.e_req});
      if (v.e_req) chk("tbl_addr", imem_addr, v.e_addr);
      chk("tbl_busy", {31'b0, fetch_busy}, {31'b0, v.e_busy});
      chk("tbl_valid_D", {31'b0, valid_D}, {31'b0, v.e_valid});
      chk("tbl_pc4_D", pc_plus4_D, v.e_pc4);
      a = v.e_pc4 - 32'd4;
      chk("tbl_instr_D", instr_D, v.e_valid ? mem_word(a) : NOP);
    end
    $display("step %0d: req=%b addr=%h rdy=%b busy=%b | instr_D=%h pc4_D=%h valid_D=%b",
             n_step, imem_req, imem_addr, v.rdy, fetch_busy, instr_D, pc_plus4_D, valid_D);
    @(posedge clk);
    model_update();
    n_step++;
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[27];
    vec_t post[2];
    vec_t r;
    logic [31:0] tmp;

    tbl[0]  = mk(1,1,0,32'h0,  1, 0,32'h0,  0, 0,32'h0);
    tbl[1]  = mk(1,1,0,32'h0,  1, 1,32'h0,  0, 0,32'h0);
    tbl[2]  = mk(1,1,0,32'h0,  1, 1,32'h4,  0, 1,32'h4);
    tbl[3]  = mk(1,1,0,32'h0,  1, 1,32'h8,  0, 1,32'h8);
    tbl[4]  = mk(1,1,0,32'h0,  1, 1,32'hC,  0, 1,32'hC);
    tbl[5]  = mk(1,1,0,32'h0,  0, 1,32'h10, 1, 1,32'h10);
    tbl[6]  = mk(1,1,0,32'h0,  0, 1,32'h10, 1, 0,32'h10);
    tbl[7]  = mk(1,1,0,32'h0,  0, 1,32'h10, 1, 0,32'h10);
    tbl[8]  = mk(1,1,0,32'h0,  1, 1,32'h10, 0, 0,32'h10);
    tbl[9]  = mk(1,1,0,32'h0,  1, 1,32'h14, 0, 1,32'h14);
    tbl[10] = mk(1,1,0,32'h0,  1, 1,32'h18, 0, 1,32'h18);
    tbl[11] = mk(1,1,0,32'h0,  1, 1,32'h1C, 0, 1,32'h1C);
    tbl[12] = mk(1,0,0,32'h0,  1, 1,32'h20, 0, 1,32'h20);
    tbl[13] = mk(0,0,0,32'h0,  1, 0,32'h0,  0, 1,32'h20);
    tbl[14] = mk(1,1,0,32'h0,  1, 0,32'h0,  0, 1,32'h20);
    tbl[15] = mk(1,1,0,32'h0,  1, 1,32'h24, 0, 1,32'h24);
    tbl[16] = mk(1,1,1,32'h100,1, 1,32'h28, 0, 1,32'h28);
    tbl[17] = mk(1,1,0,32'h0,  1, 1,32'h100,0, 0,32'h28);
    tbl[18] = mk(1,1,0,32'h0,  1, 1,32'h104,0, 1,32'h104);
    tbl[19] = mk(1,1,1,32'h40, 1, 1,32'h108,0, 1,32'h108);
    tbl[20] = mk(1,1,0,32'h0,  0, 1,32'h40, 1, 0,32'h108);
    tbl[21] = mk(1,1,1,32'h200,0, 1,32'h40, 1, 0,32'h108);
    tbl[22] = mk(1,1,0,32'h0,  0, 1,32'h40, 1, 0,32'h108);
    tbl[23] = mk(1,1,0,32'h0,  1, 1,32'h40, 0, 0,32'h108);
    tbl[24] = mk(1,1,0,32'h0,  1, 1,32'h200,0, 0,32'h108);
    tbl[25] = mk(1,1,0,32'h0,  0, 1,32'h204,1, 1,32'h204);
    tbl[26] = mk(1,1,0,32'h0,  0, 1,32'h204,1, 0,32'h204);
    post[0] = mk(1,1,0,32'h0,  1, 0,32'h0,  0, 0,32'h0);
    post[1] = mk(1,1,0,32'h0,  1, 1,32'h0,  0, 0,32'h0);

    rst = 1'b1;
    stall_F_n = 1'b1; stall_D_n = 1'b1; pc_src_D = 1'b0; pc_branch_D = 32'h0; imem_ready = 1'b1;
    #3;
    check_reset_outputs("reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    for (int i = 0; i < 27; i++) step(tbl[i], 1'b1);

    // Asynchronous reset in the middle of a WAIT at 0x204.
    #3;
    chk("pre_reset_busy", {31'b0, fetch_busy}, 32'd1);
    rst = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 2; i++) step(post[i], 1'b1);

    for (int i = 0; i < 1200; i++) begin
      r.sf  = ($urandom_range(0, 4) != 0);
      r.sd  = ($urandom_range(0, 4) != 0);
      r.ps  = ($urandom_range(0, 7) == 0);
      tmp   = $urandom;
      if ($urandom_range(0, 3) == 0) r.pb = 32'hFFFF_FFF0 | (tmp & 32'h0000_000C);
      else                           r.pb = tmp & 32'h0000_FFFC;
      r.rdy = ($urandom_range(0, 3) != 0);
      r.e_req = 0; r.e_addr = 32'h0; r.e_busy = 0; r.e_valid = 0; r.e_pc4 = 32'h0;
      step(r, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch front end of the 5-stage MIPS pipeline. It owns the PC register, the instruction-memory request handshake, a one-entry hold buffer and the IF/ID pipeline register. It is the consuming end of the hazard unit's stall/redirect protocol: it honours stall_F_n, stall_D_n and the branch redirect resolved in Decode. It presents instr_D, pc_plus4_D and valid_D to Decode.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0000, encoding injected as a bubble (sll $0,$0,0)

Ports:
clk  in  1  pipeline clock
rst  in  1  asynchronous, active-high reset
stall_F_n  in  1  0 = hold PC / no new fetch issue
stall_D_n  in  1  0 = hold IF/ID register
pc_src_D  in  1  branch/jump taken, resolved in Decode
pc_branch_D  in  32  redirect target
imem_req  out  1  fetch request valid
imem_addr  out  32  word-aligned fetch address; stable while imem_req=1 and imem_ready=0
imem_ready  in  1  request accepted; imem_rdata valid in the same cycle
imem_rdata  in  32  instruction word
instr_D  out  32  IF/ID instruction
pc_plus4_D  out  32  IF/ID PC+4
valid_D  out  1  IF/ID holds a real instruction
fetch_busy  out  1  request outstanding (imem_req=1 and imem_ready=0)

Behaviour:
- Reset (async, any cycle, including mid-request): pc_F=RESET_PC, state=IDLE, hold_valid=0, kill=0, instr_D=NOP_INSTR, pc_plus4_D=0, valid_D=0, imem_req=0, fetch_busy=0.
- FSM states:
  - IDLE: entered from reset. Moves to REQ on the next clock. No request is issued.
  - REQ: imem_req=1 and imem_addr=pc_F when stall_F_n=1 and hold_valid=0; otherwise imem_req=0.
  - WAIT: request issued but imem_ready=0. imem_req stays 1 and imem_addr stays frozen, even if stall_F_n drops or a redirect arrives.
- Accept (imem_req and imem_ready):
  - If kill=1: data discarded, kill cleared, pc_F unchanged (already holds the target). Next state REQ.
  - Otherwise pc_F <= pc_F+4 (mod 2^32, wraps).
    - If stall_D_n=1: IF/ID <= {imem_rdata, pc_F+4, 1}.
    - If stall_D_n=0: hold buffer <= {imem_rdata, pc_F+4}, hold_valid=1.
- IF/ID update when stall_D_n=1 and no accept:
  - If hold_valid: load from the hold buffer, clear hold_valid.
  - Else: load bubble {NOP_INSTR, unchanged pc_plus4_D, 0}.
- Hold: stall_D_n=0 freezes IF/ID exactly.
- Redirect (pc_src_D=1 and stall_D_n=1) takes priority over accept and hold-buffer load:
  - pc_F <= pc_branch_D; IF/ID <= bubble; hold_valid <= 0.
  - If in WAIT with no same-cycle accept: kill <= 1.
  - A same-cycle accept is dropped.
- pc_src_D while stall_D_n=0 is ignored (the branch is not yet resolved).
- Latency: accept in cycle N, visible on instr_D in cycle N+1.
- fetch_busy is combinational from the state and imem_ready.

Optional Feature:
DELAY_SLOT_EN
- Defined: MIPS branch delay slot. On redirect, the instruction being accepted, or the hold-buffer entry, is loaded into IF/ID as valid rather than squashed. If that slot word is still outstanding (WAIT), it is not killed; it is delivered when accepted, and pc_F then takes pc_branch_D from a saved redirect register instead of pc_F+4.
- Undefined: squash semantics as above; the redirect register is not instantiated.

Decomposition:
- fetch_pkg: fetch_state_e {IDLE, REQ, WAIT}, NOP_INSTR default, ifid_t struct {instr, pc_plus4, valid}.
- One sub-module: fetch_hold_buf, a one-entry buffer with load, drain and clear; ports in/out ifid_t.
- PC, FSM and IF/ID register stay in fetch_stage.

Test Plan:
- Reset release, imem_ready tied 1 → addresses 0,4,8 issued on consecutive cycles from cycle 2; instr_D follows one cycle later with valid_D=1, pc_plus4_D=4,8,12.
- imem_ready low 3 cycles at addr 0x10 → imem_addr held at 0x10 and fetch_busy=1 for 3 cycles; valid_D=0 during the wait; the word arrives with pc_plus4_D=0x14.
- stall_F_n=stall_D_n=0 for 2 cycles while accepting 0x20 → IF/ID frozen, hold_valid=1, no new request; on release instr_D=word@0x20, then fetch at 0x24.
- pc_src_D=1, pc_branch_D=0x100 with ready=1 → next cycle valid_D=0 and instr_D=NOP_INSTR, imem_addr=0x100; the squashed word never appears on instr_D.
- Redirect to 0x200 during WAIT at 0x40 → 0x40 held until ready, its data discarded, then 0x200 requested; with DELAY_SLOT_EN the word@0x40 appears with valid_D=1 before 0x200.
- rst asserted mid-WAIT → outputs return to reset values immediately; first request after release is RESET_PC.
